// File: rtl/non_restoring_divider_if.sv
// Operand/result bundle for non_restoring_divider. The master drives the operands
// and the slave (the divider) returns the registered quotient and remainder.
interface non_restoring_divider_if #(
    parameter int n = 64
);
    logic [n-1:0] dividend;
    logic [n-1:0] divisor;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;

    modport master (
        output dividend,
        output divisor,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  dividend,
        input  divisor,
        output quotient,
        output remainder
    );
endinterface

// File: rtl/non_restoring_divider.sv
// Fully pipelined unsigned non-restoring divider: one operation per clock, n+2 edge latency.
// Optional simulation self-check is compiled in with NRD_ASSERT_EN.
module non_restoring_divider #(
    parameter int n = 64
) (
    input logic                   clk,
    input logic                   reset,
    non_restoring_divider_if.slave bus
);

    // One non-restoring step. The shifted value may wrap in n+1 bits, but the
    // result always lands in [-D, D), so modulo arithmetic gives the right answer.
    function automatic logic [2*n:0] nr_step(
        input logic [n:0]   a,
        input logic [n-1:0] q,
        input logic [n-1:0] d
    );
        logic [n:0] a_sh;
        logic [n:0] a_new;
        a_sh  = {a[n-1:0], q[n-1]};
        a_new = a[n] ? (a_sh + {1'b0, d}) : (a_sh - {1'b0, d});
        return {a_new, q[n-2:0], ~a_new[n]};
    endfunction

    logic [n:0]   a_q [0:n];
    logic [n-1:0] q_q [0:n];
    logic [n-1:0] d_q [0:n];
    logic         v_q [0:n];

    logic [n-1:0] quot_r;
    logic [n-1:0] rem_r;
    logic [n:0]   a_fix;

    assign a_fix = a_q[n][n] ? (a_q[n] + {1'b0, d_q[n]}) : a_q[n];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= n; i++) begin
                a_q[i] <= '0;
                q_q[i] <= '0;
                d_q[i] <= '0;
                v_q[i] <= 1'b0;
            end
            quot_r <= '0;
            rem_r  <= '0;
        end else begin
            a_q[0] <= '0;
            q_q[0] <= bus.dividend;
            d_q[0] <= bus.divisor;
            v_q[0] <= 1'b1;
            for (int i = 1; i <= n; i++) begin
                {a_q[i], q_q[i]} <= nr_step(a_q[i-1], q_q[i-1], d_q[i-1]);
                d_q[i]           <= d_q[i-1];
                v_q[i]           <= v_q[i-1];
            end
            // Outputs hold until a real operation arrives, so reset never shows garbage.
            if (v_q[n]) begin
                quot_r <= q_q[n];
                rem_r  <= a_fix[n-1:0];
            end
        end
    end

    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;

`ifdef NRD_ASSERT_EN
    logic [n-1:0] chk_dvd [0:n];
    logic [n-1:0] chk_dvs [0:n];
    logic [n-1:0] chk_exp_q;
    logic [n-1:0] chk_exp_r;
    logic         chk_v;
    int unsigned  mismatch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= n; i++) begin
                chk_dvd[i] <= '0;
                chk_dvs[i] <= '0;
            end
            chk_exp_q    <= '0;
            chk_exp_r    <= '0;
            chk_v        <= 1'b0;
            mismatch_cnt <= 0;
        end else begin
            chk_dvd[0] <= bus.dividend;
            chk_dvs[0] <= bus.divisor;
            for (int i = 1; i <= n; i++) begin
                chk_dvd[i] <= chk_dvd[i-1];
                chk_dvs[i] <= chk_dvs[i-1];
            end
            chk_v <= v_q[n];
            if (v_q[n]) begin
                if (chk_dvs[n] == '0) begin
                    chk_exp_q <= '1;
                    chk_exp_r <= chk_dvd[n];
                end else begin
                    chk_exp_q <= chk_dvd[n] / chk_dvs[n];
                    chk_exp_r <= chk_dvd[n] % chk_dvs[n];
                end
            end
            if (chk_v && (quot_r != chk_exp_q || rem_r != chk_exp_r)) begin
                $error("non_restoring_divider: q=%h r=%h expected q=%h r=%h",
                       quot_r, rem_r, chk_exp_q, chk_exp_r);
                mismatch_cnt <= mismatch_cnt + 1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_non_restoring_divider.sv
// Scoreboard bench for non_restoring_divider (n=64): expected results are queued with
// their due edge when operands are driven and compared when that edge arrives.
module tb_non_restoring_divider;
    localparam int N = 64;

    typedef struct {
        int           due;
        logic [N-1:0] q;
        logic [N-1:0] r;
    } exp_t;

    logic clk;
    logic reset;
    non_restoring_divider_if #(.n(N)) bus ();

    non_restoring_divider #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb[$];
    int           edge_cnt;
    int           tests;
    int           fails;
    logic [N-1:0] hold_q;
    logic [N-1:0] hold_r;

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Drive one clock: operands (or reset), then update the model and compare outputs.
    task automatic cycle(input logic rst, input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input string tag);
        exp_t e;
        reset        = rst;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        edge_cnt++;
        #1;
        if (rst) begin
            sb.delete();
            hold_q = '0;
            hold_r = '0;
        end else begin
            e.due = edge_cnt + N + 1;
            e.q   = eq;
            e.r   = er;
            sb.push_back(e);
        end
        if (sb.size() > 0 && sb[0].due == edge_cnt) begin
            e = sb.pop_front();
            hold_q = e.q;
            hold_r = e.r;
        end
        check_val({tag, ".q"}, bus.quotient, hold_q);
        check_val({tag, ".r"}, bus.remainder, hold_r);
    endtask

    task automatic op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                      input logic [N-1:0] eq, input logic [N-1:0] er, input string tag);
        cycle(1'b0, dvd, dvs, eq, er, tag);
    endtask

    task automatic op_rand(input string tag);
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        dvd = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       dvs = '0;
            1:       dvs = N'($urandom_range(1, 20));
            2:       dvs = {32'd0, $urandom};
            3:       dvs = dvd;
            default: dvs = {$urandom, $urandom};
        endcase
        if (dvs == '0) op(dvd, dvs, '1, dvd, tag);
        else           op(dvd, dvs, dvd / dvs, dvd % dvs, tag);
    endtask

    localparam logic [N-1:0] ONES = '1;
    localparam logic [N-1:0] MSB  = {1'b1, {(N-1){1'b0}}};

    initial begin
        edge_cnt = 0;
        tests    = 0;
        fails    = 0;
        hold_q   = '0;
        hold_r   = '0;

        cycle(1'b1, 64'd7, 64'd3, '0, '0, "rst");
        cycle(1'b1, 64'd9, 64'd2, '0, '0, "rst");

        op(64'd0, 64'd0, ONES, 64'd0, "zero_by_zero");
        op(64'd11, 64'd3, 64'd3, 64'd2, "11_3");
        op(64'd15, 64'd5, 64'd3, 64'd0, "15_5");
        op(64'd100, 64'd3, 64'd33, 64'd1, "100_3");
        op(64'd2147483647, 64'd1505034, 64'd1426, 64'd1305163, "big_div");
        op(64'd2147483647, 64'd2147483647, 64'd1, 64'd0, "equal");
        op(64'd49, 64'd100, 64'd0, 64'd49, "small");
        op(ONES, 64'd1, ONES, 64'd0, "max_by_1");
        op(ONES, MSB, 64'd1, MSB - 64'd1, "max_by_msb");
        op(64'd5, 64'd0, ONES, 64'd5, "div_zero");
        op(MSB, ONES, 64'd0, MSB, "msb_by_max");
        op(ONES, ONES, 64'd1, 64'd0, "max_by_max");
        for (int i = 0; i < N + 4; i++) op_rand("stream");

        for (int i = 0; i < 10; i++) op_rand("inflight");
        cycle(1'b1, 64'd1, 64'd1, '0, '0, "midrst");
        op(64'd1000, 64'd7, 64'd142, 64'd6, "post_rst");
        for (int i = 0; i < 300; i++) op_rand("rand");
        for (int i = 0; i < N + 2; i++) op_rand("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
